// File: rtl/pll_reset_seq.sv
// pll_reset_seq
//   Power-up / recovery sequencer for a transceiver PLL that runs from an
//   external clock chip. It waits for the clock chip to report it is
//   configured, pulses the PLL reset, waits for lock, and checks that lock
//   stays up for a settle period. Only then does it release the reset of the
//   recovered-clock domain. Configuration and lock timeouts request a rewrite
//   of the clock chip. After MAX_RETRIES such requests the sequencer parks in
//   FAIL.
//
//   Optional feature macro: PLL_RESET_SEQ_LOL_RECOVERY_EN
//     defined   : loss of lock in RUN re-enters PLL_RST. retry_count does not
//                 change.
//     undefined : RUN is terminal and loss of lock is ignored.
//
// Ports
//   clk            in   system clock (50 MHz), the only clock
//   reset_n        in   asynchronous active-low reset
//   conf_ready     in   clock chip configured (asynchronous, synchronised here)
//   pll_locked     in   transceiver PLL lock (asynchronous, synchronised here)
//   conf_retrigger out  one-cycle request to rewrite the clock chip
//   pll_reset      out  active-high transceiver PLL reset
//   user_reset_n   out  active-low reset for the recovered-clock domain
//   seq_done       out  high while in RUN
//   seq_fail       out  high while in FAIL
//   retry_count    out  clock-chip rewrites requested since reset (saturates)
//
// State table
//   state      | meaning
//   WAIT_CONF  | PLL held in reset; conf_ready ignored for START_DELAY cycles,
//              | then awaited until START_DELAY+CONF_TIMEOUT cycles
//   PLL_RST    | PLL reset asserted for PLL_RST_CYCLES cycles
//   WAIT_LOCK  | PLL reset released; wait up to LOCK_TIMEOUT cycles for lock
//   SETTLE     | lock must hold SETTLE_CYCLES consecutive cycles
//   RUN        | sequence complete, recovered-clock logic out of reset
//   RETRY      | single cycle: request clock-chip rewrite, count the retry
//   FAIL       | retries exhausted; terminal until reset_n

module pll_reset_seq #(
    parameter int START_DELAY    = 64,
    parameter int CONF_TIMEOUT   = 1000000,
    parameter int PLL_RST_CYCLES = 50,
    parameter int LOCK_TIMEOUT   = 500000,
    parameter int SETTLE_CYCLES  = 5000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       conf_ready,
    input  logic       pll_locked,
    output logic       conf_retrigger,
    output logic       pll_reset,
    output logic       user_reset_n,
    output logic       seq_done,
    output logic       seq_fail,
    output logic [3:0] retry_count
);

    typedef enum logic [2:0] {
        ST_WAIT_CONF,
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_RUN,
        ST_RETRY,
        ST_FAIL
    } state_t;

    // The counter holds the number of cycles already spent in the current
    // state. A state that must last N cycles therefore exits when it reads N-1.
    localparam logic [19:0] START_TC   = 20'(START_DELAY);
    localparam logic [19:0] CONF_TC    = 20'(START_DELAY + CONF_TIMEOUT - 1);
    localparam logic [19:0] PLL_RST_TC = 20'(PLL_RST_CYCLES - 1);
    localparam logic [19:0] LOCK_TC    = 20'(LOCK_TIMEOUT - 1);
    localparam logic [19:0] SETTLE_TC  = 20'(SETTLE_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRIES);

    state_t      state;
    state_t      state_nxt;
    logic [19:0] cnt;
    logic [19:0] cnt_nxt;
    logic [3:0]  retry_nxt;

    logic conf_meta;
    logic conf_sync;
    logic lock_meta;
    logic lock_sync;

    logic conf_retrigger_nxt;
    logic pll_reset_nxt;
    logic user_reset_n_nxt;
    logic seq_done_nxt;
    logic seq_fail_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conf_meta <= 1'b0;
            conf_sync <= 1'b0;
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            conf_meta <= conf_ready;
            conf_sync <= conf_meta;
            lock_meta <= pll_locked;
            lock_sync <= lock_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_WAIT_CONF;
            cnt            <= '0;
            retry_count    <= '0;
            conf_retrigger <= 1'b0;
            pll_reset      <= 1'b1;
            user_reset_n   <= 1'b0;
            seq_done       <= 1'b0;
            seq_fail       <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            retry_count    <= retry_nxt;
            conf_retrigger <= conf_retrigger_nxt;
            pll_reset      <= pll_reset_nxt;
            user_reset_n   <= user_reset_n_nxt;
            seq_done       <= seq_done_nxt;
            seq_fail       <= seq_fail_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_count;

        case (state)
            ST_WAIT_CONF: begin
                if ((cnt >= START_TC) && conf_sync) begin
                    state_nxt = ST_PLL_RST;
                end else if (cnt == CONF_TC) begin
                    state_nxt = ST_RETRY;
                end
            end
            ST_PLL_RST: begin
                if (cnt == PLL_RST_TC) begin
                    state_nxt = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                // When lock and timeout arrive in the same cycle, lock wins.
                if (lock_sync) begin
                    state_nxt = ST_SETTLE;
                end else if (cnt == LOCK_TC) begin
                    state_nxt = ST_RETRY;
                end
            end
            ST_SETTLE: begin
                if (!lock_sync) begin
                    state_nxt = ST_WAIT_LOCK;
                end else if (cnt == SETTLE_TC) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
`ifdef PLL_RESET_SEQ_LOL_RECOVERY_EN
                if (!lock_sync) begin
                    state_nxt = ST_PLL_RST;
                end
`endif
            end
            ST_RETRY: begin
                // retry_count was already incremented on entry to RETRY.
                if (retry_count >= RETRY_MAX) begin
                    state_nxt = ST_FAIL;
                end else begin
                    state_nxt = ST_WAIT_CONF;
                end
            end
            ST_FAIL: begin
                state_nxt = ST_FAIL;
            end
            default: begin
                state_nxt = ST_WAIT_CONF;
            end
        endcase

        if ((state_nxt == ST_RETRY) && (retry_count != 4'hF)) begin
            retry_nxt = retry_count + 4'd1;
        end

        if (state_nxt != state) begin
            cnt_nxt = '0;
        end else if (cnt == '1) begin
            cnt_nxt = cnt;
        end else begin
            cnt_nxt = cnt + 20'd1;
        end

        // Outputs are decoded from the next state and then registered. This
        // keeps them glitch-free and aligned with the state they describe.
        conf_retrigger_nxt = (state_nxt == ST_RETRY);
        pll_reset_nxt      = (state_nxt == ST_WAIT_CONF) || (state_nxt == ST_PLL_RST) ||
                             (state_nxt == ST_RETRY)     || (state_nxt == ST_FAIL);
        user_reset_n_nxt   = (state_nxt == ST_RUN);
        seq_done_nxt       = (state_nxt == ST_RUN);
        seq_fail_nxt       = (state_nxt == ST_FAIL);
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Testbench for pll_reset_seq.
// Each test fills per-cycle waveforms for conf_ready and pll_locked. A phase
// model computes, from those waveforms, the cycles at which the output vector
// should change, and the bench queues those changes. A monitor compares every
// observed output change against the queue. It also checks the outputs
// immediately after each asynchronous reset assertion.
// The bench honours PLL_RESET_SEQ_LOL_RECOVERY_EN in the same way as the design.

module tb_pll_reset_seq;

    localparam int SD   = 4;
    localparam int CT   = 100;
    localparam int PRC  = 5;
    localparam int LT   = 50;
    localparam int SC   = 10;
    localparam int MAXR = 2;
    localparam int N    = 360;

    // Output vector: {conf_retrigger, pll_reset, user_reset_n, seq_done, seq_fail, retry_count}
    localparam logic [8:0] RST_O = 9'b0_1_0_0_0_0000;

    typedef enum logic [2:0] {P_WC, P_PR, P_WL, P_ST, P_RUN, P_RT, P_FAIL} phase_t;
    typedef struct {
        int         cyc;
        logic [8:0] o;
    } ev_t;

    logic       clk;
    logic       reset_n;
    logic       conf_ready;
    logic       pll_locked;
    logic       conf_retrigger;
    logic       pll_reset;
    logic       user_reset_n;
    logic       seq_done;
    logic       seq_fail;
    logic [3:0] retry_count;

    bit   conf_w [N];
    bit   lock_w [N];
    ev_t  exp_q[$];
    int   cyc;
    int   total;
    int   bad;

    pll_reset_seq #(
        .START_DELAY   (SD),
        .CONF_TIMEOUT  (CT),
        .PLL_RST_CYCLES(PRC),
        .LOCK_TIMEOUT  (LT),
        .SETTLE_CYCLES (SC),
        .MAX_RETRIES   (MAXR)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .conf_ready    (conf_ready),
        .pll_locked    (pll_locked),
        .conf_retrigger(conf_retrigger),
        .pll_reset     (pll_reset),
        .user_reset_n  (user_reset_n),
        .seq_done      (seq_done),
        .seq_fail      (seq_fail),
        .retry_count   (retry_count)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // A value driven for cycle n reaches the decision logic two edges later.
    function automatic bit seen_c(input int p);
        if (p < 2 || p - 2 >= N) return 1'b0;
        return conf_w[p-2];
    endfunction

    function automatic bit seen_l(input int p);
        if (p < 2 || p - 2 >= N) return 1'b0;
        return lock_w[p-2];
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [8:0] outs_of(input phase_t ph, input int rc);
        logic [8:0] o;
        o[8]   = (ph == P_RT);
        o[7]   = (ph == P_WC) || (ph == P_PR) || (ph == P_RT) || (ph == P_FAIL);
        o[6]   = (ph == P_RUN);
        o[5]   = (ph == P_RUN);
        o[4]   = (ph == P_FAIL);
        o[3:0] = 4'(rc);
        return o;
    endfunction

    // Phase walk: for each phase entered at cycle e, compute the cycle p at
    // which it is left and the next phase. Queue an event when the output
    // vector changes at that cycle.
    task automatic build_expect(input int limit);
        phase_t     ph;
        phase_t     nx;
        int         e;
        int         p;
        int         rc;
        bit         hit;
        logic [8:0] po;
        logic [8:0] o;
        ev_t        ev;
        ph = P_WC;
        e  = 0;
        rc = 0;
        po = RST_O;
        forever begin
            hit = 1'b0;
            p   = 0;
            nx  = ph;
            case (ph)
                P_WC: begin
                    for (int k = SD; k < SD + CT && !hit; k++)
                        if (seen_c(e + k)) begin hit = 1'b1; p = e + k; end
                    if (hit) nx = P_PR;
                    else begin p = e + SD + CT - 1; nx = P_RT; end
                end
                P_PR: begin
                    p  = e + PRC - 1;
                    nx = P_WL;
                end
                P_WL: begin
                    for (int k = 0; k < LT && !hit; k++)
                        if (seen_l(e + k)) begin hit = 1'b1; p = e + k; end
                    if (hit) nx = P_ST;
                    else begin p = e + LT - 1; nx = P_RT; end
                end
                P_ST: begin
                    for (int k = 0; k < SC && !hit; k++) begin
                        if (!seen_l(e + k)) begin
                            hit = 1'b1; p = e + k; nx = P_WL;
                        end else if (k == SC - 1) begin
                            hit = 1'b1; p = e + k; nx = P_RUN;
                        end
                    end
                end
                P_RUN: begin
`ifdef PLL_RESET_SEQ_LOL_RECOVERY_EN
                    for (int q = e; q <= limit && !hit; q++)
                        if (!seen_l(q)) begin hit = 1'b1; p = q; nx = P_PR; end
`endif
                    if (!hit) p = limit + 1;
                end
                P_RT: begin
                    p  = e;
                    nx = (rc >= MAXR) ? P_FAIL : P_WC;
                end
                default: p = limit + 1;
            endcase
            if (p > limit) break;
            if (nx == P_RT && rc < 15) rc = rc + 1;
            o = outs_of(nx, rc);
            if (o != po) begin
                ev.cyc = p;
                ev.o   = o;
                exp_q.push_back(ev);
            end
            po = o;
            ph = nx;
            e  = p + 1;
        end
    endtask

    task automatic clr_waves();
        for (int n = 0; n < N; n++) begin
            conf_w[n] = 1'b0;
            lock_w[n] = 1'b0;
        end
    endtask

    task automatic conf_from(input int a);
        for (int n = a; n < N; n++) conf_w[n] = 1'b1;
    endtask

    task automatic lock_set(input int a, input int b, input bit v);
        for (int n = a; n <= b && n < N; n++) lock_w[n] = v;
    endtask

    // Cycle at which pll_reset drops for the first attempt when conf_ready
    // rises at cycle c.
    function automatic int pll_fall(input int c);
        return imax(c + 2, SD) + PRC;
    endfunction

    // Queue the expected changes, release reset, drive the waveforms through
    // cycle 'last', then assert reset asynchronously between clock edges.
    task automatic run_test(input int last);
        build_expect(last);
        @(negedge clk);
        conf_ready = conf_w[0];
        pll_locked = lock_w[0];
        cyc        = -1;
        reset_n    = 1'b1;
        for (int n = 0; n <= last; n++) begin
            @(posedge clk);
            cyc = n;
            @(negedge clk);
            if (n + 1 < N) begin
                conf_ready = conf_w[n+1];
                pll_locked = lock_w[n+1];
            end
        end
        #2;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        conf_ready = 1'b0;
        pll_locked = 1'b0;
    endtask

    // Monitor and scoreboard.
    initial begin : monitor
        logic [8:0] prev;
        logic [8:0] cur;
        bit         rst_prev;
        ev_t        ev;
        prev     = RST_O;
        rst_prev = 1'b1;
        forever begin
            @(negedge clk or negedge reset_n);
            if (!reset_n) begin
                if (rst_prev) begin
                    #1;
                    cur = {conf_retrigger, pll_reset, user_reset_n, seq_done, seq_fail, retry_count};
                    total++;
                    if (cur !== RST_O) begin
                        bad++;
                        $display("FAIL reset_outputs got=%b expected=%b t=%0t", cur, RST_O, $time);
                    end
                    total++;
                    if (exp_q.size() != 0) begin
                        bad++;
                        $display("FAIL pending_events left=%0d expected=0 next_cyc=%0d",
                                 exp_q.size(), exp_q[0].cyc);
                    end
                    exp_q.delete();
                    prev = RST_O;
                end
                rst_prev = 1'b0;
            end else begin
                rst_prev = 1'b1;
                cur = {conf_retrigger, pll_reset, user_reset_n, seq_done, seq_fail, retry_count};
                if (cur !== prev) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_change cyc=%0d got=%b prev=%b", cyc, cur, prev);
                    end else begin
                        ev = exp_q.pop_front();
                        if (ev.cyc != cyc || ev.o !== cur) begin
                            bad++;
                            $display("FAIL output_change got cyc=%0d %b expected cyc=%0d %b",
                                     cyc, cur, ev.cyc, ev.o);
                        end
                    end
                    prev = cur;
                end
            end
        end
    end

    initial begin : stim
        int c;
        int d;
        int l;
        int v;
        int i;
        int len;
        int last;
        total      = 0;
        bad        = 0;
        cyc        = -1;
        reset_n    = 1'b1;
        conf_ready = 1'b0;
        pll_locked = 1'b0;
        #5 reset_n = 1'b0;
        repeat (3) @(posedge clk);

        // Nominal bring-up: conf at cycle 20, lock 10 cycles after pll_reset drops.
        clr_waves();
        conf_from(20);
        lock_set(pll_fall(20) + 10, N - 1, 1'b1);
        run_test(N - 2);

        // Clock chip never ready: two retrigger pulses, then FAIL.
        clr_waves();
        run_test(N - 2);

        // Lock never arrives.
        clr_waves();
        c = $urandom_range(0, 30);
        conf_from(c);
        run_test(N - 2);

        // Lock drops for one cycle at settle cycle 7.
        clr_waves();
        c = $urandom_range(0, 30);
        d = $urandom_range(1, 20);
        conf_from(c);
        l = pll_fall(c) + d;
        lock_set(l, N - 1, 1'b1);
        lock_w[l+8] = 1'b0;
        run_test(N - 2);

        // Lock lost for 3 cycles while in RUN.
        clr_waves();
        c = $urandom_range(0, 30);
        d = $urandom_range(1, 20);
        conf_from(c);
        l = pll_fall(c) + d;
        lock_set(l, N - 1, 1'b1);
        lock_set(l + 20, l + 22, 1'b0);
        run_test(N - 2);

        // Reset asserted during the first retrigger pulse.
        clr_waves();
        run_test(SD + CT - 1);

        // Randomised waveforms, some aborted by reset mid-sequence.
        for (int t = 0; t < 8; t++) begin
            clr_waves();
            conf_from($urandom_range(0, 140));
            v = $urandom_range(0, 1);
            i = 0;
            while (i < N) begin
                len = (v != 0) ? $urandom_range(3, 40) : $urandom_range(1, 25);
                lock_set(i, i + len - 1, v[0]);
                i = i + len;
                v = 1 - v;
            end
            last = (t % 2 == 0) ? N - 2 : $urandom_range(40, N - 2);
            run_test(last);
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
